bpu_update_sched: RTL and testbench
===================================

// Module: bpu_update_sched
// PURPOSE
// Sits between the backend and the BPU. It schedules all writes into the BPU's BTB/PHT/RAS update port.
// - After reset, sweeps every BTB/PHT index to invalidate it, because the BTB BRAM and the PHT array have no reset.
// - Then arbitrates the EXU (mispredict) and commit (PHT training) update sources into one FIFO.
// - Issues at most one bpu_update_req_t per cycle and spaces same-index PHT updates so the BPU's 1-cycle PHT read-modify-write never reads stale state.
// PARAMETERS
// NUM_BTB_ENTRIES  512  BTB/PHT depth; must match the BPU; power of two
// FIFO_DEPTH       4    update queue depth; power of two, >=2
// STARVE_LIMIT     3    consecutive EXU wins while commit waits before commit is forced
// PORTS
// clk          in   1                   clock
// rst          in   1                   asynchronous, active-high reset
// exu_req      in   $bits(bpu_update_req_t)  EXU update; .valid is the request
// exu_ready    out  1                   EXU request accepted this cycle
// cmt_req      in   $bits(bpu_update_req_t)  commit update; .valid is the request
// cmt_ready    out  1                   commit request accepted this cycle
// update_req   out  $bits(bpu_update_req_t)  to BPU; registered; .valid pulses 1 cycle per issue
// clr_en       out  1                   BTB valid bit / PHT entry clear strobe
// clr_idx      out  BTB_INDEX_WIDTH     index being cleared
// busy_clear   out  1                   high while the sweep is running
// BEHAVIOUR
// - Index of a request: index(pc) = pc[BTB_INDEX_WIDTH+1:2], where BTB_INDEX_WIDTH = $clog2(NUM_BTB_ENTRIES).
// - Reset state: FSM=S_CLEAR; clr_idx=0; clr_en=1; busy_clear=1; exu_ready=cmt_ready=0; update_req='0; FIFO empty; starve_cnt=0; last_br_valid=0.
// - Reset is asynchronous. Asserting rst at any time discards the FIFO and drops update_req.valid immediately (no clock edge needed). The sweep then restarts at index 0.
// - S_CLEAR:
//   - clr_en=1 every cycle; clr_idx counts 0..NUM_BTB_ENTRIES-1.
//   - When clr_idx reaches the last index, the FSM goes to S_RUN at the next edge, with clr_en=0 and busy_clear=0.
//   - Both readies stay 0 throughout the sweep.
//   - The BPU ORs clr_en into its BTB write (valid=0) and writes STRONG_NOT_TAKEN into the PHT.
// - S_RUN, accept side (combinational ready, at most one push per cycle):
//   - force_cmt = cmt_req.valid && starve_cnt==STARVE_LIMIT.
//   - grant_exu = exu_req.valid && !force_cmt.
//   - grant_cmt = cmt_req.valid && !grant_exu.
//   - exu_ready = grant_exu && !full; cmt_ready = grant_cmt && !full. There is no push-when-full bypass, even when a pop happens in the same cycle.
// - starve_cnt:
//   - Increments (saturating) on an EXU push while cmt_req.valid.
//   - Clears on a commit push, or in any cycle with cmt_req.valid=0.
//   - Holds otherwise.
// - Issue side, evaluated each cycle on the FIFO head:
//   - hazard = last_br_valid && head.is_branch_inst && index(head.pc)==last_br_idx.
//   - If the FIFO is non-empty and there is no hazard: pop; update_req <= head with valid=1.
//   - Otherwise: update_req.valid <= 0.
//   - last_br_valid <= (popped && head.is_branch_inst); last_br_idx <= index(head.pc).
//   - Net effect: same-index branch updates are issued at least 2 cycles apart. All other pairs may issue back-to-back.
// - Latency: a request pushed at edge N is visible at the FIFO head in cycle N+1. With an empty FIFO and no hazard, update_req.valid is high in the cycle after edge N+1.
// - FIFO: read/write pointers are $clog2(FIFO_DEPTH)+1 bits wide and wrap naturally. full = MSBs differ and LSBs are equal; empty = pointers equal. Pushes and pops in the same cycle are both allowed when not full.
// - Update ordering: updates are architectural and are never dropped. The BPU flush input does not affect this block. Order within each source is preserved.
// STRUCTURE
// - Package bundle: bpu_update_req_t (existing), sched_state_t {S_CLEAR, S_RUN}.
// - Package bitutils: generic sync FIFO helper types, if needed.
// - Sub-module bpu_upd_fifo #(WIDTH, DEPTH): register-based sync FIFO with async-high reset and push/pop/full/empty/head. Arbitration, starvation counter, hazard check and clear FSM stay in the top module.
// TESTING (NUM_BTB_ENTRIES=8, FIFO_DEPTH=4, STARVE_LIMIT=3 unless noted)
// 1. Release rst -> clr_en=1 for exactly 8 cycles with clr_idx 0..7, then busy_clear=0 and ready follows valid.
// 2. One EXU push {pc=0x80000010, is_branch_inst=1} at edge N -> update_req.valid=1 for one cycle after edge N+1, fields equal to input.
// 3. exu and cmt valid every cycle, FIFO kept draining -> push order E,E,E,C,E,E,E,C; starve_cnt returns to 0 after each C.
// 4. Two branch pushes pc=0x80000010 then 0x80000030 (same index 4) -> issues 2 cycles apart. Same test with pc=0x80000014 second -> issues back-to-back.
// 5. Four pushes while head blocked by a hazard -> full; exu_ready=0 with exu_req.valid=1. The fifth request is accepted the cycle after the first pop.
// 6. Assert rst mid-stream with 3 entries queued -> update_req.valid=0 before the next edge. After release, the sweep restarts at clr_idx=0 and the old entries never issue.

Source files
------------

// File: rtl/bpu_update_sched_pkg.sv
// -----------------------------------------------------------------------------
// bpu_update_sched_pkg
// Shared types for the BPU update scheduler and its neighbours.
//   bpu_update_req_t : one BTB/PHT/RAS update as seen on the BPU update port.
//                      .valid marks a live request; the index into the BTB/PHT
//                      is taken from pc[BTB_INDEX_WIDTH+1:2].
//   sched_state_t    : scheduler mode, sweeping (S_CLEAR) or serving (S_RUN).
// -----------------------------------------------------------------------------
package bpu_update_sched_pkg;

  localparam int DEF_NUM_BTB_ENTRIES = 512;
  localparam int DEF_FIFO_DEPTH      = 4;
  localparam int DEF_STARVE_LIMIT    = 3;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] target;
    logic        is_branch_inst;
    logic        taken;
    logic        is_call;
    logic        is_ret;
  } bpu_update_req_t;

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } sched_state_t;

endpackage

// File: rtl/bpu_update_sched_if.sv
// -----------------------------------------------------------------------------
// bpu_update_sched_if
// Update traffic between the backend sources, the scheduler and the BPU.
//   exu_req / exu_ready   : mispredict updates from the EXU, ready = accepted
//   cmt_req / cmt_ready   : PHT training updates from commit, ready = accepted
//   update_req            : single registered update stream into the BPU
// modport master : backend/BPU side (drives requests, observes the rest)
// modport slave  : the scheduler
// -----------------------------------------------------------------------------
interface bpu_update_sched_if;
  import bpu_update_sched_pkg::*;

  bpu_update_req_t exu_req;
  logic            exu_ready;
  bpu_update_req_t cmt_req;
  logic            cmt_ready;
  bpu_update_req_t update_req;

  modport master (
    output exu_req,
    output cmt_req,
    input  exu_ready,
    input  cmt_ready,
    input  update_req
  );

  modport slave (
    input  exu_req,
    input  cmt_req,
    output exu_ready,
    output cmt_ready,
    output update_req
  );

endinterface

// File: rtl/bpu_update_sched_fifo.sv
// -----------------------------------------------------------------------------
// bpu_upd_fifo
// Register-based synchronous FIFO holding queued BPU updates.
//   clk, rst   : clock, asynchronous active-high reset (empties the queue)
//   push_i     : write data_i this cycle (ignored when full)
//   data_i     : entry to enqueue
//   pop_i      : drop the head entry this cycle (ignored when empty)
//   head_o     : oldest entry, valid whenever empty_o is low
//   full_o     : no room for another push
//   empty_o    : nothing queued
// Pointers carry one extra wrap bit so full and empty can be told apart.
// -----------------------------------------------------------------------------
module bpu_upd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_q + PTR_ONE;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/bpu_update_sched.sv
// -----------------------------------------------------------------------------
// bpu_update_sched
// Owns the BPU update port. After reset it sweeps every BTB/PHT index with a
// clear strobe (those arrays have no reset), then merges EXU and commit
// updates through a small FIFO and issues at most one update per cycle,
// holding back a branch update whose index was written the cycle before so
// the BPU's one-cycle PHT read-modify-write never sees stale state.
//   clk, rst      : clock, asynchronous active-high reset
//   upd_if        : slave modport (exu_req/exu_ready, cmt_req/cmt_ready,
//                   registered update_req to the BPU)
//   clr_en_o      : BTB valid / PHT entry clear strobe during the sweep
//   clr_idx_o     : index being cleared
//   busy_clear_o  : sweep in progress
// -----------------------------------------------------------------------------
module bpu_update_sched
  import bpu_update_sched_pkg::*;
#(
  parameter int NUM_BTB_ENTRIES = DEF_NUM_BTB_ENTRIES,
  parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
  parameter int STARVE_LIMIT    = DEF_STARVE_LIMIT,
  localparam int BTB_INDEX_WIDTH = $clog2(NUM_BTB_ENTRIES)
) (
  input  logic                       clk,
  input  logic                       rst,
  bpu_update_sched_if.slave          upd_if,
  output logic                       clr_en_o,
  output logic [BTB_INDEX_WIDTH-1:0] clr_idx_o,
  output logic                       busy_clear_o
);

  localparam int IW       = BTB_INDEX_WIDTH;
  localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int REQ_W    = $bits(bpu_update_req_t);

  localparam logic [IW-1:0]       LAST_IDX   = IW'(NUM_BTB_ENTRIES - 1);
  localparam logic [IW-1:0]       IDX_ONE    = 1;
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [STARVE_W-1:0] STARVE_ONE = 1;

  sched_state_t        state_q;
  logic                clr_en_q;
  logic                busy_q;
  logic [IW-1:0]       clr_idx_q;
  logic [STARVE_W-1:0] starve_q;
  logic                last_br_valid_q;
  logic [IW-1:0]       last_br_idx_q;
  bpu_update_req_t     upd_q;
  bpu_update_req_t     issue_d;

  logic [REQ_W-1:0]    push_data;
  logic [REQ_W-1:0]    head_raw;
  bpu_update_req_t     head;
  logic [IW-1:0]       head_idx;
  logic                fifo_full;
  logic                fifo_empty;

  logic run;
  logic force_cmt;
  logic grant_exu;
  logic grant_cmt;
  logic exu_push;
  logic cmt_push;
  logic push;
  logic hazard;
  logic pop;

  // Clear sweep: one index per cycle, then hand over to normal operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= '0;
      clr_en_q  <= 1'b1;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        S_CLEAR: begin
          if (clr_idx_q == LAST_IDX) begin
            state_q  <= S_RUN;
            clr_en_q <= 1'b0;
            busy_q   <= 1'b0;
          end else begin
            clr_idx_q <= clr_idx_q + IDX_ONE;
          end
        end
        S_RUN: begin
          state_q <= S_RUN;
        end
        default: begin
          state_q   <= S_CLEAR;
          clr_idx_q <= '0;
          clr_en_q  <= 1'b1;
          busy_q    <= 1'b1;
        end
      endcase
    end
  end

  // EXU normally wins; commit is forced in once it has lost STARVE_LIMIT
  // times in a row. A full queue refuses both, even if it pops this cycle.
  always_comb begin
    run       = (state_q == S_RUN);
    force_cmt = upd_if.cmt_req.valid && (starve_q == STARVE_MAX);
    grant_exu = run && upd_if.exu_req.valid && !force_cmt;
    grant_cmt = run && upd_if.cmt_req.valid && !grant_exu;
    exu_push  = grant_exu && !fifo_full;
    cmt_push  = grant_cmt && !fifo_full;
    push      = exu_push || cmt_push;
    push_data = grant_exu ? upd_if.exu_req : upd_if.cmt_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else if (!upd_if.cmt_req.valid || cmt_push) begin
      starve_q <= '0;
    end else if (exu_push && (starve_q != STARVE_MAX)) begin
      starve_q <= starve_q + STARVE_ONE;
    end
  end

  bpu_upd_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .head_o  (head_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A branch head that hits the index issued last cycle waits one cycle; the
  // stall itself clears last_br_valid_q, so the wait never exceeds a cycle.
  always_comb begin
    head           = bpu_update_req_t'(head_raw);
    head_idx       = head.pc[IW+1:2];
    hazard         = last_br_valid_q && head.is_branch_inst && (head_idx == last_br_idx_q);
    pop            = !fifo_empty && !hazard;
    issue_d        = head;
    issue_d.valid  = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_q           <= '0;
      last_br_valid_q <= 1'b0;
      last_br_idx_q   <= '0;
    end else begin
      upd_q           <= pop ? issue_d : '0;
      last_br_valid_q <= pop && head.is_branch_inst;
      last_br_idx_q   <= head_idx;
    end
  end

  assign upd_if.exu_ready  = exu_push;
  assign upd_if.cmt_ready  = cmt_push;
  assign upd_if.update_req = upd_q;
  assign clr_en_o          = clr_en_q;
  assign clr_idx_o         = clr_idx_q;
  assign busy_clear_o      = busy_q;

endmodule

// File: tb/tb_bpu_update_sched.sv
// -----------------------------------------------------------------------------
// tb_bpu_update_sched
// Directed bench for bpu_update_sched with an 8-entry BTB, 4-deep queue and a
// starvation limit of 3. Inputs change on the falling edge; outputs are read
// 1 time unit later. Every update seen on update_req is logged with the cycle
// number so ordering and spacing can be compared against hand-worked values.
// -----------------------------------------------------------------------------
module tb_bpu_update_sched;
  import bpu_update_sched_pkg::*;

  localparam int NUM_BTB = 8;

  logic clk;
  logic rst;
  logic       clr_en;
  logic [2:0] clr_idx;
  logic       busy_clear;

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc         = 0;

  bpu_update_req_t idleReq;
  bpu_update_req_t issQ[$];
  int              issCycQ[$];

  bpu_update_sched_if bus ();

  bpu_update_sched #(
    .NUM_BTB_ENTRIES (NUM_BTB),
    .FIFO_DEPTH      (4),
    .STARVE_LIMIT    (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .upd_if       (bus),
    .clr_en_o     (clr_en),
    .clr_idx_o    (clr_idx),
    .busy_clear_o (busy_clear)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every issued update together with the cycle it was visible in.
  always @(negedge clk) begin
    if (bus.update_req.valid) begin
      issQ.push_back(bus.update_req);
      issCycQ.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic bpu_update_req_t mkReq(logic [31:0] pc, logic [31:0] tgt, logic br);
    bpu_update_req_t r;
    r                = '0;
    r.valid          = 1'b1;
    r.pc             = pc;
    r.target         = tgt;
    r.is_branch_inst = br;
    r.taken          = br;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bpu_update_req_t e, input bpu_update_req_t c);
    @(negedge clk);
    bus.exu_req = e;
    bus.cmt_req = c;
    #1;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(idleReq, idleReq);
  endtask

  function automatic logic [31:0] issTarget(input int i);
    return (i < issQ.size()) ? issQ[i].target : 32'hDEAD_DEAD;
  endfunction

  function automatic int issGap(input int i);
    return (i + 1 < issCycQ.size()) ? issCycQ[i+1] - issCycQ[i] : -1;
  endfunction

  task automatic checkSweep(input string tag);
    checkOutput({tag, "_idx0"}, clr_idx, 0);
    checkOutput({tag, "_en0"}, clr_en, 1);
    for (int i = 1; i < NUM_BTB; i++) begin
      applyStimulus(mkReq(32'h8000_0040, 32'h1, 1'b0), idleReq);
      checkOutput({tag, "_idx"}, clr_idx, i);
      checkOutput({tag, "_en"}, clr_en, 1);
      checkOutput({tag, "_busy"}, busy_clear, 1);
      checkOutput({tag, "_exu_ready"}, bus.exu_ready, 0);
    end
    applyStimulus(idleReq, idleReq);
    checkOutput({tag, "_done_en"}, clr_en, 0);
    checkOutput({tag, "_done_busy"}, busy_clear, 0);
  endtask

  logic [31:0] expT3 [8];
  bit          expE3 [8];
  bit          expR5 [9];
  int          tag;
  int          cTag;

  initial begin
    idleReq     = '0;
    clk         = 1'b0;
    rst         = 1'b1;
    bus.exu_req = '0;
    bus.cmt_req = '0;

    // Reset state, with both sources requesting.
    #12;
    bus.exu_req = mkReq(32'h8000_0040, 32'h1, 1'b0);
    bus.cmt_req = mkReq(32'h8000_0044, 32'h2, 1'b0);
    #1;
    checkOutput("rst_clr_en", clr_en, 1);
    checkOutput("rst_clr_idx", clr_idx, 0);
    checkOutput("rst_busy", busy_clear, 1);
    checkOutput("rst_exu_ready", bus.exu_ready, 0);
    checkOutput("rst_cmt_ready", bus.cmt_ready, 0);
    checkOutput("rst_upd_valid", bus.update_req.valid, 0);
    bus.exu_req = '0;
    bus.cmt_req = '0;

    // Sweep after release, then ready follows valid.
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkSweep("sweep");
    checkOutput("run_exu_ready_idle", bus.exu_ready, 0);
    bus.exu_req = mkReq(32'h8000_0040, 32'h1, 1'b0);
    #1;
    checkOutput("run_exu_ready", bus.exu_ready, 1);
    bus.cmt_req = mkReq(32'h8000_0044, 32'h2, 1'b0);
    #1;
    checkOutput("run_both_cmt_ready", bus.cmt_ready, 0);
    bus.exu_req = '0;
    #1;
    checkOutput("run_cmt_ready", bus.cmt_ready, 1);
    bus.cmt_req = '0;
    #1;
    checkOutput("run_cmt_ready_idle", bus.cmt_ready, 0);

    // Single EXU push: visible on update_req the cycle after the next edge.
    applyStimulus(mkReq(32'h8000_0010, 32'h0000_1234, 1'b1), idleReq);
    checkOutput("lat_push_ready", bus.exu_ready, 1);
    applyStimulus(idleReq, idleReq);
    checkOutput("lat_n1_valid", bus.update_req.valid, 0);
    applyStimulus(idleReq, idleReq);
    checkOutput("lat_n2_valid", bus.update_req.valid, 1);
    checkOutput("lat_pc", bus.update_req.pc, 32'h8000_0010);
    checkOutput("lat_target", bus.update_req.target, 32'h0000_1234);
    checkOutput("lat_branch", bus.update_req.is_branch_inst, 1);
    checkOutput("lat_taken", bus.update_req.taken, 1);
    applyStimulus(idleReq, idleReq);
    checkOutput("lat_n3_valid", bus.update_req.valid, 0);
    idleCycles(3);

    // Both sources always valid: E,E,E,C,E,E,E,C.
    expE3 = '{1, 1, 1, 0, 1, 1, 1, 0};
    expT3 = '{32'hE0, 32'hE1, 32'hE2, 32'hC0, 32'hE3, 32'hE4, 32'hE5, 32'hC1};
    issQ.delete();
    issCycQ.delete();
    tag  = 0;
    cTag = 0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(mkReq(32'h8000_0100, 32'hE0 + tag, 1'b0),
                    mkReq(32'h8000_0200, 32'hC0 + cTag, 1'b0));
      checkOutput("arb_exu_ready", bus.exu_ready, expE3[c]);
      checkOutput("arb_cmt_ready", bus.cmt_ready, !expE3[c]);
      if (bus.exu_ready) tag++;
      if (bus.cmt_ready) cTag++;
    end
    idleCycles(4);
    checkOutput("arb_issue_count", issQ.size(), 8);
    for (int i = 0; i < 8; i++) checkOutput("arb_issue_order", issTarget(i), expT3[i]);

    // Same-index branches are spaced by two cycles.
    issQ.delete();
    issCycQ.delete();
    applyStimulus(mkReq(32'h8000_0010, 32'hA1, 1'b1), idleReq);
    checkOutput("haz_a_ready", bus.exu_ready, 1);
    applyStimulus(mkReq(32'h8000_0030, 32'hA2, 1'b1), idleReq);
    checkOutput("haz_b_ready", bus.exu_ready, 1);
    idleCycles(6);
    checkOutput("haz_count", issQ.size(), 2);
    checkOutput("haz_first", issTarget(0), 32'hA1);
    checkOutput("haz_second", issTarget(1), 32'hA2);
    checkOutput("haz_gap", issGap(0), 2);

    // Different index issues back-to-back.
    issQ.delete();
    issCycQ.delete();
    applyStimulus(mkReq(32'h8000_0010, 32'hB1, 1'b1), idleReq);
    checkOutput("nohaz_a_ready", bus.exu_ready, 1);
    applyStimulus(mkReq(32'h8000_0014, 32'hB2, 1'b1), idleReq);
    checkOutput("nohaz_b_ready", bus.exu_ready, 1);
    idleCycles(6);
    checkOutput("nohaz_count", issQ.size(), 2);
    checkOutput("nohaz_second", issTarget(1), 32'hB2);
    checkOutput("nohaz_gap", issGap(0), 1);

    // Continuous same-index branches fill the queue: full in cycle 7, the
    // request is taken again in cycle 8 right after the pop.
    expR5 = '{1, 1, 1, 1, 1, 1, 1, 0, 1};
    issQ.delete();
    issCycQ.delete();
    tag = 0;
    for (int c = 0; c < 9; c++) begin
      applyStimulus(mkReq(32'h8000_0010, 32'h50 + tag, 1'b1), idleReq);
      checkOutput("full_exu_ready", bus.exu_ready, expR5[c]);
      if (bus.exu_ready) tag++;
    end
    idleCycles(16);
    checkOutput("full_issue_count", issQ.size(), 8);
    for (int i = 0; i < 8; i++) checkOutput("full_issue_order", issTarget(i), 32'h50 + i);
    for (int i = 0; i < 7; i++) checkOutput("full_issue_gap", issGap(i), 2);

    // Reset mid-stream with three entries queued.
    issQ.delete();
    issCycQ.delete();
    tag = 0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(mkReq(32'h8000_0010, 32'h60 + tag, 1'b1), idleReq);
      checkOutput("mrst_push_ready", bus.exu_ready, 1);
      tag++;
    end
    applyStimulus(idleReq, idleReq);
    checkOutput("mrst_pre_valid", bus.update_req.valid, 1);
    checkOutput("mrst_pre_target", bus.update_req.target, 32'h62);
    checkOutput("mrst_pre_count", issQ.size(), 3);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("mrst_valid_drop", bus.update_req.valid, 0);
    checkOutput("mrst_clr_en", clr_en, 1);
    checkOutput("mrst_clr_idx", clr_idx, 0);
    checkOutput("mrst_busy", busy_clear, 1);
    issQ.delete();
    issCycQ.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkSweep("resweep");
    idleCycles(10);
    checkOutput("mrst_no_stale_issue", issQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
